// File: rtl/hazard_ctrl.sv
// Load-use hazard detection, redirect squash, post-reset pipeline fill and saturating event counters.
// Latency: control outputs are combinational from state and current inputs (zero cycles); counters update at the next edge.
// Backpressure: stall_f/stall_d hold the front end on a load-use; flush_d/bubble_x squash for FLUSH_CYCLES after a redirect.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-low reset
//   inst_d/inst_x/inst_m     instructions currently in D, X and M
//   redirect_x               taken branch/jal/jalr resolved in X
//   stall_f, stall_d         hold PC / hold F/D register
//   bubble_x, flush_d        load NOP into D/X / load NOP into F/D
//   busy                     controller not in RUN
//   stall_cnt, flush_cnt     saturating load-use bubble and redirect counters
module hazard_ctrl #(
    parameter logic [31:0] NOP_INST     = 32'h00000013,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          RESET_HOLD   = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      inst_d,
    input  logic [31:0]      inst_x,
    input  logic [31:0]      inst_m,
    input  logic             redirect_x,
    output logic             stall_f,
    output logic             stall_d,
    output logic             bubble_x,
    output logic             flush_d,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef enum logic [1:0] {HOLD, RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_inc, flush_inc;

    // The NOP itself is muxed into the pipeline registers downstream; this
    // block only raises the controls. Unread bits are gathered here.
    logic unused_bits;
    assign unused_bits = ^{inst_d[31:25], inst_d[14:7], inst_d[1:0],
                           inst_x[31:12], inst_x[6:0] == 7'b0 ? 1'b0 : 1'b0,
                           inst_m[31:12], NOP_INST};

    logic [4:0] opc_d;
    logic       uses_rs1, uses_rs2;
    logic       lu;

    assign opc_d    = inst_d[6:2];
    assign uses_rs1 = !(opc_d inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM});
    assign uses_rs2 = opc_d inside {OPC_OP, OPC_STORE, OPC_BRANCH};

    // Only loads produce late data; an x0 destination never carries a value.
    function automatic logic hit(input logic [31:0] s, input logic [31:0] d,
                                 input logic rs1_used, input logic rs2_used);
        hit = (s[6:2] == OPC_LOAD) && (s[11:7] != 5'd0) &&
              ((rs1_used && (s[11:7] == d[19:15])) ||
               (rs2_used && (s[11:7] == d[24:20])));
    endfunction

    assign lu = hit(inst_x, inst_d, uses_rs1, uses_rs2) |
                hit(inst_m, inst_d, uses_rs1, uses_rs2);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        bubble_x  = 1'b0;
        flush_d   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (!reset) begin
            // Reset forces HOLD-style controls immediately, whatever the state.
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_x = 1'b1;
            flush_d  = 1'b1;
        end else begin
            unique case (state_q)
                HOLD: begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    bubble_x = 1'b1;
                    flush_d  = 1'b1;
                    if (cnt_q == 3'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                RUN: begin
                    // A redirect wins over a pending load-use: the stalled pair is wrong-path.
                    if (redirect_x) begin
                        flush_d   = 1'b1;
                        bubble_x  = 1'b1;
                        flush_inc = 1'b1;
                        state_d   = FLUSH;
                        cnt_d     = 3'(FLUSH_CYCLES - 1);
                    end else if (lu) begin
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        bubble_x  = 1'b1;
                        stall_inc = 1'b1;
                    end
                end
                FLUSH: begin
                    // Both sides of any hazard are being squashed, and a redirect
                    // seen here comes from a bubble, so inputs are ignored.
                    flush_d  = 1'b1;
                    bubble_x = 1'b1;
                    if (cnt_q == 3'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                default: state_d = HOLD;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= HOLD;
            cnt_q       <= 3'(RESET_HOLD - 1);
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Counters read as zero for as long as reset is held low.
    assign stall_cnt = reset ? stall_cnt_q : '0;
    assign flush_cnt = reset ? flush_cnt_q : '0;
    assign busy      = !reset || (state_q != RUN);

endmodule
